seq_div4: RTL and testbench

SEQ_DIV4 -- requirements
Module: seq_div4

---
 rtl/seq_div4.sv | 98 +++++++++
 tb/tb_seq_div4.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_div4.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Quot/Rem/Dz are updated only when the FSM enters DONE (or on reset).
module seq_div4 #(
    parameter int unsigned WIDTH = 4  // must be >= 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quot,
    output logic [WIDTH-1:0] Rem,
    output logic             busy,
    output logic             done,
    output logic             Dz
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] dvd;   // dividend bits shift out the top, quotient bits shift in below
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] prem;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   pshift;
    logic [WIDTH+1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] pnext;
    logic [WIDTH-1:0] qnext;
    logic             unused_diff;

    // Subtract as P' + ~B + 1; the carry out of the WIDTH+1 bit field means no borrow.
    always_comb begin
        pshift = {prem, dvd[WIDTH-1]};
        diff   = {1'b0, pshift} + {1'b0, ~{1'b0, dvs}} + {{(WIDTH + 1){1'b0}}, 1'b1};
        ge     = diff[WIDTH+1];
        pnext  = ge ? diff[WIDTH-1:0] : pshift[WIDTH-1:0];
        qnext  = {dvd[WIDTH-2:0], ge};
    end

    // The restored remainder is always below B, so this bit is zero whenever it is used.
    assign unused_diff = diff[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dvd   <= '0;
            dvs   <= '0;
            prem  <= '0;
            cnt   <= '0;
            Quot  <= '0;
            Rem   <= '0;
            Dz    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (B != '0) begin
                            dvd   <= A;
                            dvs   <= B;
                            prem  <= '0;
                            cnt   <= '0;
                            state <= CALC;
                        end else begin
                            Quot  <= '1;
                            Rem   <= A;
                            Dz    <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                CALC: begin
                    dvd  <= qnext;
                    prem <= pnext;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        Quot  <= qnext;
                        Rem   <= pnext;
                        Dz    <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_div4.sv
// Directed and randomized checks of seq_div4 against an arithmetic (/, %) reference.
module tb_seq_div4;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         busy;
    logic         done;
    logic         dz;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_div4 #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (a),
        .B    (b),
        .Quot (quot),
        .Rem  (rem),
        .busy (busy),
        .done (done),
        .Dz   (dz)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One division from IDLE. If inject > 0, a competing start is pulsed on that cycle.
    task automatic run(input logic [W-1:0] av, input logic [W-1:0] bv, input int inject,
                       input logic [W-1:0] ia, input logic [W-1:0] ib, input string tag);
        logic [W-1:0] eq, er, q0, r0;
        int           elat, lat, nbusy;
        bit           overlap, changed;
        eq   = (bv == 0) ? '1 : av / bv;
        er   = (bv == 0) ? av : av % bv;
        elat = (bv == 0) ? 1 : W + 1;
        start = 1'b1;
        a     = av;
        b     = bv;
        tick();
        start   = 1'b0;
        a       = W'($urandom);
        b       = W'($urandom);
        q0      = quot;
        r0      = rem;
        lat     = 0;
        nbusy   = 0;
        overlap = 0;
        changed = 0;
        for (int c = 1; c <= 20; c++) begin
            if (busy) nbusy++;
            if (busy && done) overlap = 1;
            if (done) begin
                lat = c;
                break;
            end
            if (quot !== q0 || rem !== r0) changed = 1;
            if (c == inject) begin
                start = 1'b1;
                a     = ia;
                b     = ib;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check($sformatf("%s latency", tag), lat, elat);
        check($sformatf("%s busy_cycles", tag), nbusy, (bv == 0) ? 0 : W);
        check($sformatf("%s busy_done_overlap", tag), 32'(overlap), 0);
        check($sformatf("%s early_output_change", tag), 32'(changed), 0);
        check($sformatf("%s quot", tag), quot, eq);
        check($sformatf("%s rem", tag), rem, er);
        check($sformatf("%s dz", tag), dz, (bv == 0));
        if (bv != 0) begin
            check($sformatf("%s identity", tag), int'(quot) * int'(bv) + int'(rem), av);
            check($sformatf("%s rem_lt_b", tag), 32'(rem < bv), 1);
        end
        tick();
        check($sformatf("%s done_single_pulse", tag), done, 0);
    endtask

    initial begin
        bit seen_done;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("reset quot", quot, 0);
        check("reset rem", rem, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset dz", dz, 0);
        rst = 1'b0;
        tick();

        run(4'd13, 4'd4, 0, 4'd0, 4'd0, "13/4");
        run(4'd15, 4'd1, 0, 4'd0, 4'd0, "15/1");
        run(4'd3, 4'd7, 0, 4'd0, 4'd0, "3/7");
        run(4'd0, 4'd5, 0, 4'd0, 4'd0, "0/5");
        run(4'd9, 4'd0, 0, 4'd0, 4'd0, "9/0");
        run(4'd8, 4'd2, 0, 4'd0, 4'd0, "8/2 after dz");
        run(4'd6, 4'd3, 2, 4'd14, 4'd5, "6/3 ignore start in calc");

        // start held high through DONE is taken in the following IDLE cycle
        start = 1'b1;
        a     = 4'd7;
        b     = 4'd2;
        tick();
        repeat (4) tick();
        check("held done_cycle5", done, 1);
        tick();
        check("held idle_done", done, 0);
        check("held idle_busy", busy, 0);
        tick();
        check("held reaccept_busy", busy, 1);
        start = 1'b0;
        for (int c = 0; c < 10 && !done; c++) tick();
        check("held done_reached", done, 1);
        check("held quot", quot, 3);
        check("held rem", rem, 1);
        tick();

        // reset in the middle of CALC aborts without a done pulse
        run(4'd9, 4'd0, 0, 4'd0, 4'd0, "9/0 before abort");
        start = 1'b1;
        a     = 4'd12;
        b     = 4'd5;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort in_calc", busy, 1);
        rst = 1'b1;
        tick();
        check("abort quot", quot, 0);
        check("abort rem", rem, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort dz", dz, 0);
        rst       = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 8; c++) begin
            if (done || busy) seen_done = 1;
            tick();
        end
        check("abort no_activity", 32'(seen_done), 0);
        run(4'd12, 4'd5, 0, 4'd0, 4'd0, "12/5 after abort");

        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                run(W'(ai), W'(bi), 0, 4'd0, 4'd0, $sformatf("sweep %0d/%0d", ai, bi));
            end
        end

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            run(ra, rb, int'($urandom_range(0, 6)), W'($urandom), W'($urandom),
                $sformatf("rand %0d/%0d", ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
